// File: rtl/router_pkg.sv
// Shared types for the three-channel packet router: channel index, arbiter states
// and the round-robin successor helper.
package router_pkg;

    localparam int NCH_DEF = 3;
    localparam int DW_DEF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef logic [1:0] chan_idx_t;

    // Successor of a channel index, wrapping at nch so the index never reaches nch.
    function automatic chan_idx_t next_chan(input chan_idx_t c, input int nch);
        if (int'(c) + 1 >= nch) begin
            return chan_idx_t'(0);
        end
        return c + chan_idx_t'(1);
    endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// FIFO-side and output-port signals of the router output arbiter.
// The master modport is the arbiter; the slave modport is the FIFOs plus the downstream port.
interface router_out_arbiter_if
    import router_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
);
    logic [NCH-1:0]    vld_in;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]    read_enb;
    logic [DW-1:0]     out_data;
    chan_idx_t         out_chan;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  vld_in, data_in, out_ready,
        output read_enb, out_data, out_chan, out_valid, out_last
    );

    modport slave (
        output vld_in, data_in, out_ready,
        input  read_enb, out_data, out_chan, out_valid, out_last
    );

endinterface

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or after rr_ptr, mod NCH.
module router_rr_pick
    import router_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] req,
    input  chan_idx_t      rr_ptr,
    output chan_idx_t      gnt_idx,
    output logic           any_req
);

    int   idx;
    logic hit;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        hit     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_ptr) + i) % NCH;
            hit = 1'b0;
            for (int j = 0; j < NCH; j++) begin
                if (j == idx) begin
                    hit = req[j];
                end
            end
            if (!any_req && hit) begin
                any_req = 1'b1;
                gnt_idx = chan_idx_t'(idx);
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Round-robin burst arbiter sharing one output bus among the router's show-ahead FIFOs.
// Define ROUTER_ARB_WDOG_EN to build in the sticky output-stall watchdog (stall_err).
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DW          = DW_DEF,
    parameter int BURST_MAX   = 4,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    router_out_arbiter_if.master bus,
    output logic                 busy,
    output logic                 stall_err
);

    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_MAX - 1);

    if (NCH < 2 || NCH > 4) begin : g_bad_nch
        $error("router_out_arbiter: NCH must be within 2..4");
    end
    if (BURST_MAX < 1) begin : g_bad_burst
        $error("router_out_arbiter: BURST_MAX must be at least 1");
    end
    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("router_out_arbiter: WDOG_CYCLES must be at least 2");
    end

    arb_state_t     state_q, state_d;
    chan_idx_t      gnt_q, gnt_d;
    chan_idx_t      rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;

    chan_idx_t      pick_idx;
    logic           any_req;
    logic           head_vld;
    logic [DW-1:0]  head_data;
    logic           xfer;
    logic           out_valid;
    logic           handshake;
    logic           out_last;

    router_rr_pick #(.NCH(NCH)) u_pick (
        .req     (bus.vld_in),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_comb begin
        head_vld  = 1'b0;
        head_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_q == chan_idx_t'(k)) begin
                head_vld  = bus.vld_in[k];
                head_data = bus.data_in[k*DW +: DW];
            end
        end
    end

    // Gating with resetn keeps a reset cycle from popping a FIFO mid-burst.
    assign xfer      = (state_q == XFER);
    assign out_valid = resetn && xfer && head_vld;
    assign handshake = out_valid && bus.out_ready;
    assign out_last  = out_valid && (beat_cnt_q == LAST_BEAT);

    always_comb begin
        bus.read_enb = '0;
        for (int k = 0; k < NCH; k++) begin
            if (handshake && (gnt_q == chan_idx_t'(k))) begin
                bus.read_enb[k] = 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_valid ? head_data : '0;
    assign bus.out_chan  = gnt_q;
    assign busy          = xfer;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d      = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                // A drained channel gives up the rest of its burst.
                if (!head_vld) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_chan(gnt_q, NCH);
                end else if (handshake) begin
                    if (out_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_chan(gnt_q, NCH);
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef ROUTER_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          stall_err_q, stall_err_d;
    logic          stalled;

    // out_valid already implies XFER, so leaving XFER clears the count too.
    assign stalled = out_valid && !bus.out_ready;

    always_comb begin
        wdog_cnt_d  = '0;
        stall_err_d = stall_err_q;
        if (stalled) begin
            if (wdog_cnt_q != WW'(WDOG_CYCLES)) begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q;
            end
            if (wdog_cnt_q == WW'(WDOG_CYCLES - 1)) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wdog_cnt_q  <= '0;
            stall_err_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err = stall_err_q;
`else
    assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: a cycle vector table plus FIFO-model
// scenarios whose expected output beats are queued on a scoreboard.
module tb_router_out_arbiter;
    import router_pkg::*;

    localparam int NCH         = 3;
    localparam int DW          = 8;
    localparam int BURST_MAX   = 4;
    localparam int WDOG_CYCLES = 16;

    typedef struct packed {
        logic [2:0] vld;
        logic       rdy;
        logic       e_valid;
        logic [1:0] e_chan;
        logic [7:0] e_data;
        logic       e_last;
        logic [2:0] e_read;
        logic       e_busy;
    } vec_t;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic resetn;
    logic busy;
    logic stall_err;

    router_out_arbiter_if #(.NCH(NCH), .DW(DW)) bus ();

    router_out_arbiter #(
        .NCH         (NCH),
        .DW          (DW),
        .BURST_MAX   (BURST_MAX),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .busy      (busy),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs [15];
    beat_t      exp_q [$];
    int         hs_cycles [$];
    logic [7:0] f0 [$];
    logic [7:0] f1 [$];
    logic [7:0] f2 [$];
    int         pop_cnt [3];
    int         scn_cycle;
    int         stall_run;
    int         stall_lo;
    int         stall_hi;
    logic       use_window;
    logic       ready_v;
    logic       prev_stall;
    beat_t      prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic expect_beat(input int ch, input logic [7:0] d, input logic last);
        beat_t b;
        b.chan = 2'(ch);
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic push_byte(input int ch, input logic [7:0] d);
        case (ch)
            0:       f0.push_back(d);
            1:       f1.push_back(d);
            default: f2.push_back(d);
        endcase
    endtask

    function automatic logic fifos_empty();
        return (f0.size() == 0) && (f1.size() == 0) && (f2.size() == 0);
    endfunction

    task automatic check_output();
        beat_t      got;
        beat_t      want;
        logic [2:0] rd;
        logic [2:0] vld;
        rd  = bus.read_enb;
        vld = bus.vld_in;
        got.chan = bus.out_chan;
        got.data = bus.out_data;
        got.last = bus.out_last;
        check("read_enb_legal", ((rd & ~vld) == 3'b000) && ($countones(rd) <= 1), 1'b1);
        if (bus.out_valid && bus.out_ready) begin
            hs_cycles.push_back(scn_cycle);
            if (exp_q.size() == 0) begin
                fail_now("beat_unexpected");
            end else begin
                want = exp_q.pop_front();
                check("beat", got, want);
            end
        end
        if (!bus.out_valid) begin
            check("data_zero_when_invalid", bus.out_data, 8'h00);
        end
        if (prev_stall && bus.out_valid) begin
            check("stall_hold", got, prev_beat);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_beat  = got;
        stall_run  = (bus.out_valid && !bus.out_ready) ? stall_run + 1 : 0;
    endtask

    // One clock of FIFO-model stimulus: drive at negedge, sample, pop after posedge.
    task automatic apply_stimulus();
        logic [2:0] rd;
        @(negedge clk);
        if (use_window) begin
            ready_v = !(scn_cycle >= stall_lo && scn_cycle <= stall_hi);
        end
        bus.vld_in       = {f2.size() != 0, f1.size() != 0, f0.size() != 0};
        bus.data_in      = '0;
        if (f0.size() != 0) bus.data_in[7:0]   = f0[0];
        if (f1.size() != 0) bus.data_in[15:8]  = f1[0];
        if (f2.size() != 0) bus.data_in[23:16] = f2[0];
        bus.out_ready = ready_v;
        #1;
        check_output();
        rd = bus.read_enb;
        @(posedge clk);
        if (rd[0] && f0.size() != 0) begin void'(f0.pop_front()); pop_cnt[0]++; end
        if (rd[1] && f1.size() != 0) begin void'(f1.pop_front()); pop_cnt[1]++; end
        if (rd[2] && f2.size() != 0) begin void'(f2.pop_front()); pop_cnt[2]++; end
        scn_cycle++;
    endtask

    task automatic run_scenario(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !fifos_empty()) && n < budget) begin
            apply_stimulus();
            n++;
        end
        if (n >= budget) begin
            fail_now({name, "_timeout"});
        end
        apply_stimulus();
        apply_stimulus();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn        = 1'b0;
        bus.vld_in    = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        f0.delete();
        f1.delete();
        f2.delete();
        exp_q.delete();
        hs_cycles.delete();
        for (int k = 0; k < 3; k++) pop_cnt[k] = 0;
        prev_stall = 1'b0;
        stall_run  = 0;
        use_window = 1'b0;
        ready_v    = 1'b1;
        @(negedge clk);
        resetn    = 1'b1;
        scn_cycle = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        vecs[0]  = '{3'b110, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{3'b110, 1'b0, 1'b1, 2'd1, 8'hA1, 1'b0, 3'b000, 1'b1};
        vecs[2]  = '{3'b110, 1'b1, 1'b1, 2'd1, 8'hA1, 1'b0, 3'b010, 1'b1};
        vecs[3]  = '{3'b100, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 3'b000, 1'b1};
        vecs[4]  = '{3'b100, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[5]  = '{3'b101, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b0, 3'b100, 1'b1};
        vecs[6]  = '{3'b101, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b0, 3'b100, 1'b1};
        vecs[7]  = '{3'b101, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b0, 3'b100, 1'b1};
        vecs[8]  = '{3'b101, 1'b0, 1'b1, 2'd2, 8'hB2, 1'b1, 3'b000, 1'b1};
        vecs[9]  = '{3'b101, 1'b1, 1'b1, 2'd2, 8'hB2, 1'b1, 3'b100, 1'b1};
        vecs[10] = '{3'b101, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[11] = '{3'b001, 1'b1, 1'b1, 2'd0, 8'hC0, 1'b0, 3'b001, 1'b1};
        vecs[12] = '{3'b000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b1};
        vecs[13] = '{3'b110, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 1'b0};
        vecs[14] = '{3'b110, 1'b0, 1'b1, 2'd1, 8'hA1, 1'b0, 3'b000, 1'b1};

        prev_stall = 1'b0;
        stall_run  = 0;
        scn_cycle  = 0;
        use_window = 1'b0;
        ready_v    = 1'b1;

        resetn        = 1'b0;
        bus.vld_in    = 3'b111;
        bus.data_in   = 24'hB2A1C0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs",
              {bus.read_enb, bus.out_data, bus.out_chan, bus.out_valid, bus.out_last, busy, stall_err}, '0);
        bus.vld_in = 3'b000;
        resetn     = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.vld_in    = vecs[i].vld;
            bus.data_in   = 24'hB2A1C0;
            bus.out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i),
                  {bus.out_valid, bus.out_chan, bus.out_data, bus.out_last, bus.read_enb, busy},
                  {vecs[i].e_valid, vecs[i].e_chan, vecs[i].e_data, vecs[i].e_last,
                   vecs[i].e_read, vecs[i].e_busy});
        end

        // Reset lands mid-burst on channel 1 with the round-robin pointer at 1.
        @(negedge clk);
        resetn        = 1'b0;
        bus.vld_in    = 3'b111;
        bus.out_ready = 1'b1;
        #1;
        check("reset_cycle_no_pop", {bus.read_enb, bus.out_valid}, '0);
        @(negedge clk);
        resetn        = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        check("post_reset_outputs",
              {bus.read_enb, bus.out_data, bus.out_chan, bus.out_valid, bus.out_last, busy, stall_err}, '0);
        @(negedge clk);
        #1;
        check("first_grant_after_reset", {busy, bus.out_valid, bus.out_chan, bus.out_data},
              {1'b1, 1'b1, 2'd0, 8'hC0});

        // Single channel, six bytes: 4-beat burst, bubble, 2-beat remainder.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_byte(0, 8'(8'h10 + i));
            expect_beat(0, 8'(8'h10 + i), i == 3);
        end
        run_scenario(40, "single_channel");
        check("single_pop_count", pop_cnt[0], 6);
        check("single_hs_count", hs_cycles.size(), 6);
        if (hs_cycles.size() == 6) begin
            check("request_latency", hs_cycles[0], 1);
            check("back_to_back_beats", hs_cycles[1] - hs_cycles[0], 1);
            check("bubble_between_grants", hs_cycles[4] - hs_cycles[3], 2);
        end

        // Three channels with eight bytes each: 0,1,2,0,1,2 bursts.
        do_reset();
        for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < 8; i++) push_byte(ch, 8'((ch + 1) * 32 + i));
        end
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int i = 0; i < 4; i++) expect_beat(ch, 8'((ch + 1) * 32 + r * 4 + i), i == 3);
            end
        end
        run_scenario(80, "three_channels");
        check("three_pop_counts", {8'(pop_cnt[0]), 8'(pop_cnt[1]), 8'(pop_cnt[2])}, {8'd8, 8'd8, 8'd8});

        // Backpressure for five cycles in the middle of a burst.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_byte(2, 8'(8'h80 + i));
            expect_beat(2, 8'(8'h80 + i), i == 3);
        end
        use_window = 1'b1;
        stall_lo   = 3;
        stall_hi   = 7;
        run_scenario(40, "backpressure");
        use_window = 1'b0;
        ready_v    = 1'b1;
        check("backpressure_pop_count", pop_cnt[2], 6);

        // Early drain: channel 1 releases after two beats without out_last.
        do_reset();
        push_byte(1, 8'h51);
        push_byte(1, 8'h52);
        expect_beat(1, 8'h51, 1'b0);
        expect_beat(1, 8'h52, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_byte(2, 8'(8'h61 + i));
            expect_beat(2, 8'(8'h61 + i), i == 3);
        end
        run_scenario(40, "early_drain");
        check("early_drain_pops", {8'(pop_cnt[1]), 8'(pop_cnt[2])}, {8'd2, 8'd4});

`ifdef ROUTER_ARB_WDOG_EN
        do_reset();
        push_byte(0, 8'h70);
        expect_beat(0, 8'h70, 1'b0);
        ready_v = 1'b0;
        n = 0;
        while (stall_run < 15 && n < 60) begin
            apply_stimulus();
            n++;
        end
        if (n >= 60) fail_now("wdog_15_wait");
        ready_v = 1'b1;
        apply_stimulus();
        check("wdog_15_stalls", stall_err, 1'b0);
        run_scenario(20, "wdog_15_drain");
        check("wdog_15_after", stall_err, 1'b0);

        push_byte(0, 8'h71);
        expect_beat(0, 8'h71, 1'b0);
        ready_v = 1'b0;
        n = 0;
        while (stall_run < 16 && n < 60) begin
            apply_stimulus();
            n++;
        end
        if (n >= 60) fail_now("wdog_16_wait");
        ready_v = 1'b1;
        apply_stimulus();
        check("wdog_16_stalls", stall_err, 1'b1);
        run_scenario(20, "wdog_16_drain");
        check("wdog_sticky", stall_err, 1'b1);
`else
        do_reset();
        push_byte(0, 8'h72);
        expect_beat(0, 8'h72, 1'b0);
        ready_v = 1'b0;
        n = 0;
        while (stall_run < 20 && n < 60) begin
            apply_stimulus();
            n++;
        end
        if (n >= 60) fail_now("long_stall_wait");
        ready_v = 1'b1;
        apply_stimulus();
        check("stall_err_tied_low", stall_err, 1'b0);
        run_scenario(20, "long_stall_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
